// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around a 1-bit full_adder1 cell.
// Operands are captured on an in_valid/in_ready handshake and added one bit pair
// per cycle, LSB first. The result is then presented on an out_valid/out_ready
// handshake and held stable until it is taken.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic count
);
  // Single-bit sum and carry.
  assign sum   = a ^ b ^ cin;
  assign count = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   a_sh_reg;
  logic [WIDTH-1:0]   b_sh_reg;
  logic [WIDTH-1:0]   sum_sh_reg;
  logic [WIDTH-1:0]   sum_sh_next;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               cout_reg;
  logic               out_valid_reg;
  logic               in_ready_reg;
  logic               busy_reg;
  logic               fa_s;
  logic               fa_c;
  logic               last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_reg;
`endif

  full_adder1 u_fa (
    .a     (a_sh_reg[0]),
    .b     (b_sh_reg[0]),
    .cin   (carry_reg),
    .sum   (fa_s),
    .count (fa_c)
  );

  // New sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH > 1) begin : g_sum_wide
      assign sum_sh_next = {fa_s, sum_sh_reg[WIDTH-1:1]};
    end else begin : g_sum_one
      assign sum_sh_next = fa_s;
    end
  endgenerate

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  // Control FSM and serial datapath; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      sum_sh_reg    <= '0;
      carry_reg     <= 1'b0;
      cnt_reg       <= '0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg     <= a;
            b_sh_reg     <= b;
            carry_reg    <= cin;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          sum_sh_reg <= sum_sh_next;
          carry_reg  <= fa_c;
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (last_bit) begin
            cout_reg      <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB is the carry feeding this final bit.
            ovf_reg       <= carry_reg ^ fa_c;
`endif
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_sh_reg;
  assign cout      = cout_reg;
  assign busy      = busy_reg;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 vector table plus directed
// multi-cycle sequences, WIDTH=4 exhaustive sweep and WIDTH=1 sanity ops.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       iv8 = 0, ir8, ov8, or8 = 0, cin8 = 0, cout8, busy8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  // WIDTH=4 instance
  logic       iv4 = 0, ir4, ov4, or4 = 0, cin4 = 0, cout4, busy4;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  // WIDTH=1 instance
  logic       iv1 = 0, ir1, ov1, or1 = 0, cin1 = 0, cout1, busy1;
  logic [0:0] a1 = 0, b1 = 0, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf4, ovf1;
`endif

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );
  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .busy(busy4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );
  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .busy(busy1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 transaction; optionally scrambles the inputs every RUN cycle.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                     input bit scramble, output logic [7:0] rs, output logic rc,
                     output logic ro, output int lat);
    int k;
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tc; iv8 = 1'b1;
    k = 0;
    while (!ir8 && k < 50) begin @(negedge clk); k++; end
    rs = '0; rc = 1'b0; ro = 1'b0; lat = -1;
    if (!ir8) begin
      check("op8_accept_timeout", 32'(ir8), 32'd1);
      iv8 = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 50) begin
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (!ov8) check("op8_done_timeout", 32'(ov8), 32'd1);
    rs = sum8; rc = cout8;
`ifdef SERIAL_ADDER_OVF_EN
    ro = ovf8;
`endif
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
  endtask

  // One transaction on the WIDTH=4 (sel=4) or WIDTH=1 (sel=1) instance with random out_ready.
  task automatic opn(input int sel, input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                     output logic [4:0] res);
    int k;
    bit r;
    @(negedge clk);
    if (sel == 4) begin a4 = ta; b4 = tb_; cin4 = tc; iv4 = 1'b1; end
    else begin a1 = ta[0]; b1 = tb_[0]; cin1 = tc; iv1 = 1'b1; end
    k = 0;
    while (!(sel == 4 ? ir4 : ir1) && k < 50) begin @(negedge clk); k++; end
    res = '1;
    if (!(sel == 4 ? ir4 : ir1)) begin
      check("opn_accept_timeout", 32'd0, 32'd1);
      iv4 = 1'b0; iv1 = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0; iv1 = 1'b0;
    k = 0;
    while (!(sel == 4 ? ov4 : ov1) && k < 50) begin @(negedge clk); k++; end
    if (!(sel == 4 ? ov4 : ov1)) begin
      check("opn_done_timeout", 32'd0, 32'd1);
      return;
    end
    // Random back-pressure; result is read on the cycle it is accepted.
    k = 0;
    forever begin
      r = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      if (r) begin
        res = (sel == 4) ? {cout4, sum4} : {3'b000, cout1, sum1};
        if (sel == 4) or4 = 1'b1; else or1 = 1'b1;
        @(negedge clk);
        or4 = 1'b0; or1 = 1'b0;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [7:0] rs;
    logic       rc, ro;
    int         lat, k;
    logic [4:0] res;

    vt[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vt[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};

    // Reset state
    #12;
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_in_ready", 32'(ir8), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf8), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      op8(vt[i].a, vt[i].b, vt[i].cin, 1'b0, rs, rc, ro, lat);
      $display("vec %0d: %h+%h+%0d -> sum=%h cout=%0d lat=%0d", i, vt[i].a, vt[i].b, vt[i].cin, rs, rc, lat);
      check("vec_sum", 32'(rs), 32'(vt[i].sum));
      check("vec_cout", 32'(rc), 32'(vt[i].cout));
      check("vec_latency", 32'(lat), 32'd8);
`ifdef SERIAL_ADDER_OVF_EN
      check("vec_ovf", 32'(ro), 32'(vt[i].ovf));
`endif
    end

    // Back-pressure in DONE with in_valid pulses
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0; iv8 = 1'b1;
    check("bp_idle_ready", 32'(ir8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    k = 0;
    while (!ov8 && k < 50) begin @(negedge clk); k++; end
    check("bp_done_reached", 32'(ov8), 32'd1);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iv8 = (i % 2 == 0);
      @(negedge clk);
      check("bp_out_valid", 32'(ov8), 32'd1);
      check("bp_sum", 32'(sum8), 32'h8D);
      check("bp_cout", 32'(cout8), 32'd0);
      check("bp_in_ready", 32'(ir8), 32'd0);
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check("bp_release_valid", 32'(ov8), 32'd0);
    check("bp_release_ready", 32'(ir8), 32'd1);
    check("bp_release_busy", 32'(busy8), 32'd0);
    op8(8'h01, 8'h02, 1'b0, 1'b0, rs, rc, ro, lat);
    $display("bp next op: 01+02 -> sum=%h cout=%0d", rs, rc);
    check("bp_next_sum", 32'({rc, rs}), 32'h003);

    // Asynchronous reset in the 3rd RUN cycle
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arst_busy_before", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_out_valid", 32'(ov8), 32'd0);
    check("arst_sum", 32'(sum8), 32'd0);
    check("arst_cout", 32'(cout8), 32'd0);
    check("arst_in_ready", 32'(ir8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h10, 8'h20, 1'b0, 1'b0, rs, rc, ro, lat);
    $display("after reset: 10+20 -> sum=%h cout=%0d", rs, rc);
    check("arst_next_sum", 32'({rc, rs}), 32'h030);

    // Inputs scrambled during RUN
    op8(8'h5A, 8'h33, 1'b0, 1'b1, rs, rc, ro, lat);
    $display("hold: 5A+33 scrambled -> sum=%h cout=%0d", rs, rc);
    check("hold_sum", 32'({rc, rs}), 32'h08D);
    op8(8'hC3, 8'h4E, 1'b1, 1'b1, rs, rc, ro, lat);
    $display("hold: C3+4E+1 scrambled -> sum=%h cout=%0d", rs, rc);
    check("hold_sum2", 32'({rc, rs}), 32'h112);

    // WIDTH=4 exhaustive sweep
    k = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          opn(4, 4'(x), 4'(y), 1'(c), res);
          ncmp++;
          if (res !== 5'(x + y + c)) begin
            nerr++;
            $display("FAIL w4_sum: %0d+%0d+%0d got %0d, expected %0d", x, y, c, res, x + y + c);
          end
          k++;
        end
    $display("w4 sweep: %0d ops", k);

    // WIDTH=1 sanity
    opn(1, 4'd1, 4'd1, 1'b1, res);
    $display("w1: 1+1+1 -> cout,sum=%b", res[1:0]);
    check("w1_111", 32'(res), 32'd3);
    opn(1, 4'd1, 4'd0, 1'b0, res);
    $display("w1: 1+0+0 -> cout,sum=%b", res[1:0]);
    check("w1_100", 32'(res), 32'd1);
    opn(1, 4'd0, 4'd1, 1'b1, res);
    $display("w1: 0+1+1 -> cout,sum=%b", res[1:0]);
    check("w1_011", 32'(res), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
